pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
- Downstream stage of the 8259-style priority resolver. Consumes the resolver's "request outranks in-service" flag and winning IR level.
- Raises INT to the CPU and runs the 8086-mode two-pulse INTA handshake. Commands ISR set / IRR clear and drives the 8-bit vector onto the data bus.
- Fully synchronous to clk. The CPU's inta_n is asynchronous and is synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the inta_n synchroniser (legal 2..3).
- SPURIOUS_LEVEL, 7, IR level reported when the request vanishes before the first INTA.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- int_req  in  1  resolver: unmasked request outranks current in-service level
- int_level  in  3  resolver: winning IR index (0 = highest priority)
- icw2_base  in  5  vector bits T7..T3 from ICW2
- aeoi  in  1  automatic-EOI mode enable
- inta_n  in  1  CPU interrupt acknowledge, active-low, asynchronous
- int_out  out  1  interrupt request to CPU
- freeze  out  1  holds resolver/IRR sampling during acknowledge
- irr_clr  out  8  one-hot one-cycle pulse: clear IRR bit
- isr_set  out  8  one-hot one-cycle pulse: set ISR bit
- isr_clr  out  8  one-hot one-cycle pulse: AEOI clear of ISR bit
- vec_data  out  8  interrupt vector
- vec_oe  out  1  data-bus drive enable for vec_data
- spurious  out  1  one-cycle pulse: spurious acknowledge occurred

Behaviour:
- Reset (async, active-high):
  - State IDLE. All outputs 0. Latched level = 0. Synchroniser flops preset to 1 (inta_n deasserted).
- inta_n path:
  - inta_n passes through SYNC_STAGES flops to give inta_s.
  - fall = previous inta_s high and current inta_s low. rise = previous low, current high.
  - All edges below refer to these registered events.
- States:
  - IDLE: int_out=0. If int_req=1, go to REQ next cycle.
  - REQ: int_out=1.
    - On fall: latch lvl. lvl=int_level if int_req=1; otherwise lvl=SPURIOUS_LEVEL and mark spur.
    - Assert freeze. Same cycle as the transition, pulse irr_clr[lvl] and isr_set[lvl] (both suppressed if spur). Go to ACK1.
    - If int_req drops before fall: stay in REQ. int_out stays asserted; the CPU must complete the cycle.
  - ACK1: int_out=1, freeze=1. On rise go to GAP.
  - GAP: int_out=0, freeze=1. On fall go to ACK2.
  - ACK2: freeze=1, vec_oe=1, vec_data={icw2_base,lvl}. On rise:
    - vec_oe=0 next cycle.
    - If aeoi=1 and not spur, pulse isr_clr[lvl].
    - If spur, pulse spurious.
    - Go to IDLE with freeze released.
- Latency:
  - int_req to int_out: 1 cycle.
  - inta_n pin edge to state change: SYNC_STAGES+1 cycles.
- vec_data holds its last value when vec_oe=0. It is don't-care off-bus.
- int_req/int_level changes after the first fall are ignored; lvl is latched.
- Back-to-back: after ACK2 reaches IDLE, a still-high int_req re-enters REQ the next cycle. There is always at least one IDLE cycle between acknowledges.
- At most one bit of irr_clr, isr_set, isr_clr is ever set, each for exactly one cycle.
- Reset mid-sequence: immediate return to IDLE. vec_oe and freeze drop asynchronously. No pending pulses are emitted.
- Out-of-order pulses: an inta_n fall while in IDLE is ignored (no vector, no pulses). A rise while in REQ is ignored.

Decomposition:
- Shared package pic_pkg:
  - state encoding typedef (IDLE, REQ, ACK1, GAP, ACK2)
  - IR_COUNT=8, LEVEL_W=3, VEC_BASE_W=5
  - one-hot decode function used by the priority resolver and this block.
- One sub-module: pic_sync_edge (parameterised synchroniser plus fall/rise detector). It is reused for other async CPU strobes (wr_n, rd_n).

Test Plan:
- Normal cycle: icw2_base=5'h08, int_req=1, int_level=3, aeoi=0 -> int_out=1 after 1 clk. First INTA: irr_clr=8'h08, isr_set=8'h08 pulse. Second INTA: vec_data=8'h43 with vec_oe=1. No isr_clr pulse.
- AEOI: same stimulus with aeoi=1, int_level=5 -> vec 8'h45. isr_clr=8'h20 pulses one cycle after second INTA rises.
- Spurious: int_req=1 then dropped to 0 before first INTA -> no irr_clr/isr_set. Vector 8'h47, spurious pulses once, no isr_clr even if aeoi=1.
- Level change during acknowledge: int_level changes 3->1 between the INTA pulses -> vector still 8'h43, pulses on bit 3 only.
- Reset mid-sequence: assert reset during ACK2 -> vec_oe, freeze, int_out go 0 without a clock edge. After release, a stray inta_n pulse yields no vector.
- Back-to-back: int_req held at 1, level 2 then 0 -> two complete sequences (vectors 8'h42, 8'h40) with one IDLE cycle between them. Each one-hot pulse is checked for single-cycle width.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style interrupt controller: IR geometry,
// acknowledge-sequencer state encoding and the level-to-one-hot decoder.
`timescale 1ns/1ps
package pic_pkg;

   localparam int IR_COUNT   = 8;
   localparam int LEVEL_W    = 3;
   localparam int VEC_BASE_W = 5;

   // Acknowledge sequencer state encoding
   typedef logic [2:0] pic_state_t;

   localparam pic_state_t ST_IDLE = 3'd0;
   localparam pic_state_t ST_REQ  = 3'd1;
   localparam pic_state_t ST_ACK1 = 3'd2;
   localparam pic_state_t ST_GAP  = 3'd3;
   localparam pic_state_t ST_ACK2 = 3'd4;

   // Decode an IR level into a one-hot IR mask
   function automatic logic [IR_COUNT-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
      logic [IR_COUNT-1:0] oh;
      oh      = '0;
      oh[lvl] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Synchroniser for an asynchronous active-low CPU strobe followed by a
// fall/rise detector on the synchronised level. The chain and the edge
// history are preset to 1 so no spurious edge is seen when reset releases.
// SYNC_STAGES is meaningful for 2..3.
`timescale 1ns/1ps
module pic_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic strobe_n,
   output logic fall,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   strobe_s;

   assign strobe_s = sync_q[SYNC_STAGES-1];

   // Shift the strobe through the synchroniser and keep one cycle of history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n};
         prev_q <= strobe_s;
      end
   end

   assign fall = prev_q & ~strobe_s;
   assign rise = ~prev_q & strobe_s;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INTA sequencer: raises INT for the resolver's winning request,
// walks the two-pulse acknowledge, commands IRR clear / ISR set on the first
// pulse, presents the vector on the second and issues the AEOI ISR clear or
// a spurious indication when the second pulse ends.
`timescale 1ns/1ps
module pic_inta_sequencer
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SPURIOUS_LEVEL = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  int_req,
   input  logic [LEVEL_W-1:0]    int_level,
   input  logic [VEC_BASE_W-1:0] icw2_base,
   input  logic                  aeoi,
   input  logic                  inta_n,
   output logic                  int_out,
   output logic                  freeze,
   output logic [IR_COUNT-1:0]   irr_clr,
   output logic [IR_COUNT-1:0]   isr_set,
   output logic [IR_COUNT-1:0]   isr_clr,
   output logic [7:0]            vec_data,
   output logic                  vec_oe,
   output logic                  spurious
);

   localparam logic [LEVEL_W-1:0] SPUR_LVL = LEVEL_W'(SPURIOUS_LEVEL);

   pic_state_t          state;
   pic_state_t          state_nxt;
   logic [LEVEL_W-1:0]  lvl;
   logic [LEVEL_W-1:0]  lvl_take;
   logic                spur;
   logic                inta_fall;
   logic                inta_rise;
   logic                take_ack;
   logic                end_ack;

   pic_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_inta_sync (
      .clk      (clk),
      .reset    (reset),
      .strobe_n (inta_n),
      .fall     (inta_fall),
      .rise     (inta_rise)
   );

   // First INTA accepted in REQ; second INTA released in ACK2. Edges in any
   // other state are ignored.
   assign take_ack = (state == ST_REQ)  && inta_fall;
   assign end_ack  = (state == ST_ACK2) && inta_rise;

   // A request that vanished before the first INTA is reported as spurious
   assign lvl_take = int_req ? int_level : SPUR_LVL;

   // Next-state decode for the two-pulse acknowledge handshake
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (int_req)   state_nxt = ST_REQ;
         ST_REQ:  if (inta_fall) state_nxt = ST_ACK1;
         ST_ACK1: if (inta_rise) state_nxt = ST_GAP;
         ST_GAP:  if (inta_fall) state_nxt = ST_ACK2;
         ST_ACK2: if (inta_rise) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Latch the acknowledged level at the first INTA and keep the vector
   // current with ICW2 until it goes on the bus; it then holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl      <= '0;
         spur     <= 1'b0;
         vec_data <= '0;
      end else if (take_ack) begin
         lvl      <= lvl_take;
         spur     <= ~int_req;
         vec_data <= {icw2_base, lvl_take};
      end else if ((state == ST_ACK1) || (state == ST_GAP)) begin
         vec_data <= {icw2_base, lvl};
      end
   end

   // Single-cycle command pulses, issued in the cycle after the INTA edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irr_clr  <= '0;
         isr_set  <= '0;
         isr_clr  <= '0;
         spurious <= 1'b0;
      end else begin
         irr_clr  <= (take_ack && int_req)       ? level_onehot(int_level) : '0;
         isr_set  <= (take_ack && int_req)       ? level_onehot(int_level) : '0;
         isr_clr  <= (end_ack && aeoi && !spur)  ? level_onehot(lvl)       : '0;
         spurious <= end_ack && spur;
      end
   end

   // Level outputs decode straight from the state so reset drops them at once
   assign int_out = (state == ST_REQ)  || (state == ST_ACK1);
   assign freeze  = (state == ST_ACK1) || (state == ST_GAP) || (state == ST_ACK2);
   assign vec_oe  = (state == ST_ACK2);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed vector table, hand-written
// back-to-back and reset sequences, and randomised acknowledges checked
// against a transaction-level model.
`timescale 1ns/1ps
module tb_pic_inta_sequencer;

   localparam int SYNC_STAGES = 2;
   localparam int SPUR_LVL    = 7;

   logic       clk = 1'b0;
   logic       reset;
   logic       int_req;
   logic [2:0] int_level;
   logic [4:0] icw2_base;
   logic       aeoi;
   logic       inta_n;
   logic       int_out;
   logic       freeze;
   logic [7:0] irr_clr;
   logic [7:0] isr_set;
   logic [7:0] isr_clr;
   logic [7:0] vec_data;
   logic       vec_oe;
   logic       spurious;

   int n_checks = 0;
   int n_fail   = 0;

   pic_inta_sequencer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .SPURIOUS_LEVEL (SPUR_LVL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .int_req   (int_req),
      .int_level (int_level),
      .icw2_base (icw2_base),
      .aeoi      (aeoi),
      .inta_n    (inta_n),
      .int_out   (int_out),
      .freeze    (freeze),
      .irr_clr   (irr_clr),
      .isr_set   (isr_set),
      .isr_clr   (isr_clr),
      .vec_data  (vec_data),
      .vec_oe    (vec_oe),
      .spurious  (spurious)
   );

   always #5 clk = ~clk;

   // Observations accumulated over one acknowledge sequence
   typedef struct {
      int         irr_n;
      logic [7:0] irr;
      int         set_n;
      logic [7:0] set_v;
      int         clr_n;
      logic [7:0] clr;
      int         spur_n;
      int         vec_n;
      logic [7:0] vec;
      int         err;
   } obs_t;

   obs_t mon;
   bit   p_irr, p_set, p_clr, p_spur, p_vec_oe, p_freeze;

   typedef struct {
      bit         aeoi;
      logic [4:0] base;
      logic [2:0] lvl;
      bit         spur;
      logic [2:0] lvl2;
      logic [7:0] exp_vec;
      logic [7:0] exp_irr;
      logic [7:0] exp_clr;
      bit         exp_spur;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse monitor on the falling edge: one-hot, one cycle wide, and placed
   // in the cycle the matching phase starts or ends.
   initial begin
      p_irr = 0; p_set = 0; p_clr = 0; p_spur = 0; p_vec_oe = 0; p_freeze = 0;
      forever begin
         @(negedge clk);
         if (irr_clr != 8'h00) begin
            mon.irr_n++;
            mon.irr |= irr_clr;
            if ($countones(irr_clr) != 1 || p_irr || !freeze || p_freeze) mon.err++;
         end
         if (isr_set != 8'h00) begin
            mon.set_n++;
            mon.set_v |= isr_set;
            if ($countones(isr_set) != 1 || p_set || !freeze || p_freeze) mon.err++;
         end
         if (isr_clr != 8'h00) begin
            mon.clr_n++;
            mon.clr |= isr_clr;
            if ($countones(isr_clr) != 1 || p_clr || vec_oe || !p_vec_oe) mon.err++;
         end
         if (spurious) begin
            mon.spur_n++;
            if (p_spur || vec_oe || !p_vec_oe) mon.err++;
         end
         if (vec_oe) begin
            if (mon.vec_n > 0 && vec_data != mon.vec) mon.err++;
            mon.vec = vec_data;
            mon.vec_n++;
         end
         p_irr    = (irr_clr != 8'h00);
         p_set    = (isr_set != 8'h00);
         p_clr    = (isr_clr != 8'h00);
         p_spur   = spurious;
         p_vec_oe = vec_oe;
         p_freeze = freeze;
      end
   end

   // Transaction-level expectation for one acknowledge
   function automatic void ref_ack(input bit a, input logic [4:0] base, input logic [2:0] lvl,
                                   input bit drop, output logic [7:0] e_vec, output logic [7:0] e_irr,
                                   output logic [7:0] e_clr, output bit e_spur);
      int granted;
      granted = drop ? SPUR_LVL : int'(lvl);
      e_vec   = 8'(int'(base) * 8 + granted);
      e_irr   = drop ? 8'h00 : 8'(1 << lvl);
      e_clr   = (a && !drop) ? e_irr : 8'h00;
      e_spur  = drop;
   endfunction

   // One full acknowledge; returns in the first cycle after freeze drops
   task automatic run_seq(input bit a, input logic [4:0] base, input logic [2:0] lvl, input bit drop,
                          input logic [2:0] lvl2, input bit req_after, input int w1, input int g,
                          input int w2, input bit from_idle, input string tag);
      int cyc;
      int fz_lat;
      mon = '{default:0};
      aeoi = a; icw2_base = base; int_level = lvl; int_req = 1'b1;
      if (from_idle) begin
         check({tag, " int_out before req"}, 32'(int_out), 0);
         tick();
         check({tag, " int_out 1 cycle after req"}, 32'(int_out), 1);
      end
      tick();
      if (drop) begin
         int_req = 1'b0;
         tick();
         check({tag, " int_out held after drop"}, 32'(int_out), 1);
      end
      inta_n = 1'b0; fz_lat = 0; cyc = 0;
      for (int i = 0; i < w1; i++) begin
         tick(); cyc++;
         if (freeze && fz_lat == 0) fz_lat = cyc;
      end
      inta_n = 1'b1;
      for (int i = 0; i < g; i++) begin
         tick(); cyc++;
         if (freeze && fz_lat == 0) fz_lat = cyc;
      end
      while (fz_lat == 0 && cyc < 20) begin
         tick(); cyc++;
         if (freeze) fz_lat = cyc;
      end
      check({tag, " inta fall to freeze cycles"}, 32'(fz_lat), SYNC_STAGES + 1);
      int_level = lvl2; int_req = req_after;
      inta_n = 1'b0;
      for (int i = 0; i < w2; i++) tick();
      inta_n = 1'b1;
      cyc = 0;
      while (freeze && cyc < 30) begin
         tick(); cyc++;
      end
      check({tag, " freeze released"}, 32'(freeze), 0);
   endtask

   task automatic check_obs(input string tag, input logic [7:0] e_vec, input logic [7:0] e_irr,
                            input logic [7:0] e_clr, input bit e_spur);
      check({tag, " irr_clr"},        32'(mon.irr),   32'(e_irr));
      check({tag, " irr_clr pulses"}, 32'(mon.irr_n), (e_irr != 0) ? 1 : 0);
      check({tag, " isr_set"},        32'(mon.set_v), 32'(e_irr));
      check({tag, " isr_set pulses"}, 32'(mon.set_n), (e_irr != 0) ? 1 : 0);
      check({tag, " isr_clr"},        32'(mon.clr),   32'(e_clr));
      check({tag, " isr_clr pulses"}, 32'(mon.clr_n), (e_clr != 0) ? 1 : 0);
      check({tag, " spurious pulses"},32'(mon.spur_n), e_spur ? 1 : 0);
      check({tag, " vec_oe seen"},    (mon.vec_n != 0) ? 1 : 0, 1);
      check({tag, " vec_data"},       32'(mon.vec),   32'(e_vec));
      check({tag, " pulse shape"},    32'(mon.err),   0);
   endtask

   initial begin
      logic [7:0] e_vec, e_irr, e_clr;
      bit         e_spur;
      bit         r_aeoi, r_drop;
      logic [4:0] r_base;
      logic [2:0] r_lvl, r_lvl2;
      int         cyc;

      //                aeoi base   lvl  spur lvl2  vec    irr    clr    spur
      tbl[0] = '{1'b0, 5'h08, 3'd3, 1'b0, 3'd3, 8'h43, 8'h08, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 5'h08, 3'd5, 1'b0, 3'd5, 8'h45, 8'h20, 8'h20, 1'b0};
      tbl[2] = '{1'b1, 5'h08, 3'd3, 1'b1, 3'd3, 8'h47, 8'h00, 8'h00, 1'b1};
      tbl[3] = '{1'b0, 5'h08, 3'd3, 1'b0, 3'd1, 8'h43, 8'h08, 8'h00, 1'b0};
      tbl[4] = '{1'b1, 5'h1F, 3'd0, 1'b0, 3'd6, 8'hF8, 8'h01, 8'h01, 1'b0};
      tbl[5] = '{1'b0, 5'h11, 3'd2, 1'b1, 3'd4, 8'h8F, 8'h00, 8'h00, 1'b1};

      mon = '{default:0};
      reset = 1'b1; int_req = 1'b0; int_level = 3'd0; icw2_base = 5'h00; aeoi = 1'b0; inta_n = 1'b1;
      #2;
      check("reset int_out",  32'(int_out),  0);
      check("reset freeze",   32'(freeze),   0);
      check("reset vec_oe",   32'(vec_oe),   0);
      check("reset irr_clr",  32'(irr_clr),  0);
      check("reset isr_set",  32'(isr_set),  0);
      check("reset isr_clr",  32'(isr_clr),  0);
      check("reset spurious", 32'(spurious), 0);
      check("reset vec_data", 32'(vec_data), 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Directed vector table
      foreach (tbl[i]) begin
         run_seq(tbl[i].aeoi, tbl[i].base, tbl[i].lvl, tbl[i].spur, tbl[i].lvl2, 1'b0,
                 2, 3, 2, 1'b1, $sformatf("vec%0d", i));
         tick(); tick();
         check_obs($sformatf("vec%0d", i), tbl[i].exp_vec, tbl[i].exp_irr, tbl[i].exp_clr, tbl[i].exp_spur);
      end

      // Back-to-back: request stays high, level 2 then 0
      run_seq(1'b0, 5'h08, 3'd2, 1'b0, 3'd0, 1'b1, 2, 2, 2, 1'b1, "b2b1");
      check("b2b idle cycle int_out", 32'(int_out), 0);
      tick();
      check("b2b re-request int_out", 32'(int_out), 1);
      check_obs("b2b1", 8'h42, 8'h04, 8'h00, 1'b0);
      run_seq(1'b0, 5'h08, 3'd0, 1'b0, 3'd0, 1'b0, 2, 2, 2, 1'b0, "b2b2");
      tick(); tick();
      check_obs("b2b2", 8'h40, 8'h01, 8'h00, 1'b0);

      // Randomised acknowledges against the transaction model
      for (int n = 0; n < 30; n++) begin
         r_aeoi = 1'($urandom_range(0, 1));
         r_base = 5'($urandom);
         r_lvl  = 3'($urandom);
         r_lvl2 = 3'($urandom);
         r_drop = ($urandom_range(0, 3) == 0);
         run_seq(r_aeoi, r_base, r_lvl, r_drop, r_lvl2, 1'b0,
                 $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1,
                 $sformatf("rand%0d", n));
         tick(); tick();
         ref_ack(r_aeoi, r_base, r_lvl, r_drop, e_vec, e_irr, e_clr, e_spur);
         check_obs($sformatf("rand%0d", n), e_vec, e_irr, e_clr, e_spur);
      end

      // Reset while the vector is on the bus
      aeoi = 1'b1; icw2_base = 5'h08; int_level = 3'd3; int_req = 1'b1;
      tick(); tick();
      inta_n = 1'b0; tick(); tick();
      inta_n = 1'b1; tick(); tick();
      cyc = 0;
      while (!freeze && cyc < 20) begin tick(); cyc++; end
      int_req = 1'b0;
      inta_n = 1'b0;
      cyc = 0;
      while (!vec_oe && cyc < 20) begin tick(); cyc++; end
      check("midrst reached vector phase", 32'(vec_oe), 1);
      #2 reset = 1'b1;
      #1;
      check("midrst vec_oe async", 32'(vec_oe),  0);
      check("midrst freeze async", 32'(freeze),  0);
      check("midrst int_out async", 32'(int_out), 0);
      inta_n = 1'b1;
      tick(); tick();
      check("midrst isr_clr in reset", 32'(isr_clr), 0);
      reset = 1'b0;
      tick(); tick();
      mon = '{default:0};
      for (int k = 0; k < 2; k++) begin
         inta_n = 1'b0; tick(); tick();
         inta_n = 1'b1; tick(); tick();
      end
      repeat (6) tick();
      check("stray vec_oe cycles",  32'(mon.vec_n),  0);
      check("stray irr_clr pulses", 32'(mon.irr_n),  0);
      check("stray isr_set pulses", 32'(mon.set_n),  0);
      check("stray isr_clr pulses", 32'(mon.clr_n),  0);
      check("stray spurious pulses",32'(mon.spur_n), 0);
      check("stray int_out",        32'(int_out),    0);
      check("stray freeze",         32'(freeze),     0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
